// File: rtl/cpc_kbd_pkg.sv
`default_nettype none
// ============================================================================
// cpc_kbd_pkg
// Shared CPC keyboard constants: row count, valid-column masks, the
// matrix-position to PS/2 set-2 scancode table and the scanner state enum.
// Revision: 1.0 - initial release
// ============================================================================
package cpc_kbd_pkg;

    localparam int CPC_ROWS = 10;

    typedef enum logic [1:0] {
        S_SETTLE = 2'd0,
        S_SAMPLE = 2'd1,
        S_EMIT   = 2'd2
    } scan_state_e;

    // Row 9 only carries DEL on column 7; the joystick lines are ignored.
    localparam logic [7:0] ROW_MASK [CPC_ROWS] = '{
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80
    };

    // CODE[row][col] : PS/2 set-2 code of the key at that matrix position.
    localparam logic [7:0] CODE [CPC_ROWS][8] = '{
        '{8'h75, 8'h74, 8'h72, 8'h01, 8'h0B, 8'h04, 8'h5A, 8'h78}, // up rt dn F9 F6 F3 ent F.
        '{8'h6B, 8'h11, 8'h83, 8'h0A, 8'h03, 8'h05, 8'h06, 8'h09}, // lt copy F7 F8 F5 F1 F2 F0
        '{8'h71, 8'h54, 8'h5A, 8'h5B, 8'h0C, 8'h12, 8'h5D, 8'h14}, // clr [ ret ] F4 sh \ ctl
        '{8'h55, 8'h4E, 8'h0E, 8'h4D, 8'h4C, 8'h52, 8'h4A, 8'h49}, // ^ - @ P ; : / .
        '{8'h45, 8'h46, 8'h44, 8'h43, 8'h4B, 8'h42, 8'h3A, 8'h41}, // 0 9 O I L K M ,
        '{8'h3E, 8'h3D, 8'h3C, 8'h35, 8'h33, 8'h3B, 8'h31, 8'h29}, // 8 7 U Y H J N spc
        '{8'h36, 8'h2E, 8'h2D, 8'h2C, 8'h34, 8'h2B, 8'h32, 8'h2A}, // 6 5 R T G F B V
        '{8'h25, 8'h26, 8'h24, 8'h1D, 8'h1B, 8'h23, 8'h21, 8'h22}, // 4 3 E W S D C X
        '{8'h16, 8'h1E, 8'h76, 8'h15, 8'h0D, 8'h1C, 8'h58, 8'h1A}, // 1 2 esc Q tab A caps Z
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h66}  // joystick..., DEL
    };

endpackage
`default_nettype wire

// File: rtl/cpc_row_debounce.sv
`default_nettype none
// ============================================================================
// cpc_row_debounce
// Per-row candidate state and agreement counter; decides when a row sample
// that differs from the accepted state has been seen often enough.
// Revision: 1.0 - initial release
// ============================================================================
module cpc_row_debounce
    import cpc_kbd_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [3:0] row_i,
    input  logic       sample_i,
    input  logic [7:0] sample_bits_i,
    input  logic [7:0] stable_bits_i,
    input  logic       clear_i,
    output logic       accept_o,
    output logic [7:0] pend_o
);

    logic [CPC_ROWS-1:0][7:0] pend_q;
    logic [CPC_ROWS-1:0][1:0] cnt_q;
    logic [7:0]               pend_d;
    logic [1:0]               cnt_d;

    // Candidate/count update for the row currently being sampled.
    always_comb begin
        pend_d = pend_q[row_i];
        cnt_d  = cnt_q[row_i];
        if (sample_bits_i == stable_bits_i) begin
            cnt_d = 2'd0;
        end else if (sample_bits_i == pend_q[row_i]) begin
            cnt_d = cnt_q[row_i] + 2'd1;
        end else begin
            pend_d = sample_bits_i;
            cnt_d  = 2'd1;
        end
    end

    // Only meaningful while sampling; the scanner ignores it otherwise.
    assign accept_o = (cnt_d == 2'(DEBOUNCE));
    assign pend_o   = pend_q[row_i];

    // Commit the update on a sample, drop the count once a row is emitted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else if (ce) begin
            if (sample_i) begin
                pend_q[row_i] <= pend_d;
                cnt_q[row_i]  <= cnt_d;
            end else if (clear_i) begin
                cnt_q[row_i] <= 2'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpc_matrix_scan.sv
`default_nettype none
// ============================================================================
// cpc_matrix_scan
// Scans a CPC keyboard matrix row by row, debounces the active-low column
// returns and emits per-key press/release events with PS/2 set-2 codes.
// Revision: 1.0 - initial release
// ============================================================================
module cpc_matrix_scan
    import cpc_kbd_pkg::*;
#(
    parameter int SETTLE   = 16,
    parameter int DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    output logic [3:0] Y,
    input  logic [7:0] X,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic [7:0] key_code
);

    scan_state_e              state_q, state_d;
    logic [3:0]               y_q, y_d, y_next;
    logic [7:0]               settle_q, settle_d;
    logic [CPC_ROWS-1:0][7:0] stable_q, stable_d;
    logic                     key_pressed_q, key_pressed_d;
    logic [7:0]               key_code_q, key_code_d;
    logic                     key_strobe_d;

    logic [7:0] sample_bits;
    logic [7:0] pend_row;
    logic [7:0] diff;
    logic [7:0] remain;
    logic [2:0] col;
    logic       accept;
    logic       sample_en;
    logic       clear_en;

    assign sample_bits = ~X & ROW_MASK[y_q];
    assign y_next      = (y_q == 4'd9) ? 4'd0 : y_q + 4'd1;
    assign sample_en   = (state_q == S_SAMPLE);
    assign clear_en    = (state_q == S_EMIT) && (remain == 8'd0);

    cpc_row_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce            (ce),
        .row_i         (y_q),
        .sample_i      (sample_en),
        .sample_bits_i (sample_bits),
        .stable_bits_i (stable_q[y_q]),
        .clear_i       (clear_en),
        .accept_o      (accept),
        .pend_o        (pend_row)
    );

    // Lowest differing column of the current row and what is left after it.
    always_comb begin
        diff = pend_row ^ stable_q[y_q];
        col  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) begin
                col = 3'(i);
            end
        end
        remain = diff & ~(8'd1 << col);
    end

    // Next-state, row advance and event generation; everything holds when ce is low.
    always_comb begin
        state_d       = state_q;
        y_d           = y_q;
        settle_d      = settle_q;
        stable_d      = stable_q;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;
        key_strobe_d  = 1'b0;
        if (ce) begin
            case (state_q)
                S_SETTLE: begin
                    if (settle_q == 8'(SETTLE - 1)) begin
                        settle_d = 8'd0;
                        state_d  = S_SAMPLE;
                    end else begin
                        settle_d = settle_q + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    if (accept) begin
                        state_d = S_EMIT;
                    end else begin
                        y_d     = y_next;
                        state_d = S_SETTLE;
                    end
                end
                S_EMIT: begin
                    if (diff != 8'd0) begin
                        key_strobe_d         = 1'b1;
                        key_code_d           = CODE[y_q][col];
                        key_pressed_d        = pend_row[col];
                        stable_d[y_q][col]   = pend_row[col];
                    end
                    // Leave on the cycle of the last event so no idle EMIT cycle is spent.
                    if (remain == 8'd0) begin
                        y_d     = y_next;
                        state_d = S_SETTLE;
                    end
                end
                default: begin
                    state_d = S_SETTLE;
                end
            endcase
        end
    end

    // Scanner state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_SETTLE;
            y_q           <= 4'd0;
            settle_q      <= 8'd0;
            stable_q      <= '0;
            key_code_q    <= 8'd0;
            key_pressed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            settle_q      <= settle_d;
            stable_q      <= stable_d;
            key_code_q    <= key_code_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    // Event outputs are valid in the EMIT cycle itself and held afterwards.
    assign Y           = y_q;
    assign key_strobe  = key_strobe_d;
    assign key_pressed = key_pressed_d;
    assign key_code    = key_code_d;

endmodule
`default_nettype wire

// File: tb/tb_cpc_matrix_scan.sv
`default_nettype none
// ============================================================================
// tb_cpc_matrix_scan
// Self-checking bench: a keyboard matrix model drives X, a per-visit model of
// the debounce rules predicts the event stream, directed and random stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpc_matrix_scan;
    import cpc_kbd_pkg::*;

    localparam int SETTLE_C = 4;
    localparam int DEB_C    = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic [3:0] Y;
    logic [7:0] X;
    logic       key_strobe;
    logic       key_pressed;
    logic [7:0] key_code;

    logic [7:0] kb [10];     // 1 = key held on the physical matrix
    logic       ce_seen;

    typedef struct {
        int         row;
        logic [7:0] code;
        logic       pressed;
        int         off;
    } ev_t;

    ev_t        exp_q [$];
    logic [7:0] m_stable [10];
    logic [7:0] m_last   [10];
    int         m_run    [10];
    logic [3:0] last_y;
    int         offset;
    int         vis_events;
    int         strobes;
    int         total;
    int         bad;

    cpc_matrix_scan #(
        .SETTLE   (SETTLE_C),
        .DEBOUNCE (DEB_C)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .Y           (Y),
        .X           (X),
        .key_strobe  (key_strobe),
        .key_pressed (key_pressed),
        .key_code    (key_code)
    );

    always #5 clk = ~clk;

    assign X = ~kb[Y];

    always @(posedge clk) ce_seen <= ce;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One visit of row r: the reported state moves to the sample once the
    // same differing value has been seen on DEB_C consecutive visits.
    function automatic int model_visit(input int r);
        logic [7:0] s;
        logic [7:0] chg;
        int         n;
        ev_t        e;
        n = 0;
        if (r > 9) return 0;
        s = kb[r] & ((r == 9) ? 8'h80 : 8'hFF);
        if (s == m_last[r]) m_run[r]++;
        else begin
            m_last[r] = s;
            m_run[r]  = 1;
        end
        if (s != m_stable[r] && m_run[r] >= DEB_C) begin
            chg = s ^ m_stable[r];
            for (int c = 0; c < 8; c++) begin
                if (chg[c]) begin
                    e.row     = r;
                    e.code    = CODE[r][c];
                    e.pressed = s[c];
                    e.off     = SETTLE_C + 1 + n;
                    exp_q.push_back(e);
                    n++;
                end
            end
            m_stable[r] = s;
        end
        return n;
    endfunction

    // Advance to the next falling edge and check the event stream there.
    task automatic tick();
        ev_t e;
        @(negedge clk);
        if (!reset_n) begin
            exp_q.delete();
            for (int i = 0; i < 10; i++) begin
                m_stable[i] = 8'h00;
                m_last[i]   = 8'h00;
                m_run[i]    = 0;
            end
            last_y     = 4'hF;
            offset     = 0;
            vis_events = 0;
        end else begin
            if (Y != last_y) begin
                if (last_y != 4'hF) begin
                    check("visit_len", 32'(offset + int'(ce_seen)), 32'(SETTLE_C + 1 + vis_events));
                    check("row_adv", 32'(Y), (last_y == 4'd9) ? 32'd0 : 32'(last_y) + 32'd1);
                end
                last_y     = Y;
                offset     = 0;
                vis_events = model_visit(int'(Y));
            end else begin
                offset += int'(ce_seen);
            end
            if (key_strobe) begin
                strobes++;
                check("ev_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ev_code", 32'(key_code), 32'(e.code));
                    check("ev_pressed", 32'(key_pressed), 32'(e.pressed));
                    check("ev_row", 32'(Y), 32'(e.row));
                    check("ev_cycle", 32'(offset), 32'(e.off));
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_strobe(input string tag, input int limit);
        int k;
        k = 0;
        tick();
        while (!key_strobe && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(key_strobe), 32'd1);
    endtask

    task automatic wait_row(input int r, input int limit);
        int k;
        k = 0;
        while (int'(Y) != r && k < limit) begin
            tick();
            k++;
        end
        check("wait_row", 32'(Y), 32'(r));
    endtask

    task automatic wait_not_row(input int r, input int limit);
        int k;
        k = 0;
        while (int'(Y) == r && k < limit) begin
            tick();
            k++;
        end
        check("wait_not_row", 32'(int'(Y) != r), 32'd1);
    endtask

    // Change a matrix row only while it is not being scanned.
    task automatic set_row(input int r, input logic [7:0] v);
        wait_not_row(r, 100);
        kb[r] = v;
    endtask

    initial begin
        int         r;
        int         s0;
        logic [3:0] y_hold;

        total   = 0;
        bad     = 0;
        strobes = 0;
        for (int i = 0; i < 10; i++) kb[i] = 8'h00;

        // Reset state
        ce      = 1'b1;
        reset_n = 1'b0;
        ticks(3);
        check("rst_y", 32'(Y), 32'd0);
        check("rst_strobe", 32'(key_strobe), 32'd0);
        check("rst_pressed", 32'(key_pressed), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Q press and release (row 8, column 3)
        set_row(8, 8'h08);
        wait_strobe("q_press_strobe", 300);
        check("q_press_code", 32'(key_code), 32'h15);
        check("q_press_pressed", 32'(key_pressed), 32'd1);
        set_row(8, 8'h00);
        wait_strobe("q_rel_strobe", 300);
        check("q_rel_code", 32'(key_code), 32'h15);
        check("q_rel_pressed", 32'(key_pressed), 32'd0);

        // Q seen on a single row-8 sample only
        set_row(8, 8'h08);
        wait_row(8, 100);
        wait_not_row(8, 100);
        kb[8] = 8'h00;
        s0 = strobes;
        ticks(150);
        check("glitch_nostrobe", 32'(strobes - s0), 32'd0);

        // Two keys in row 2: Return then Shift on consecutive cycles
        set_row(2, 8'h24);
        wait_strobe("r2_first_strobe", 300);
        check("r2_first_code", 32'(key_code), 32'h5A);
        check("r2_first_pressed", 32'(key_pressed), 32'd1);
        check("r2_first_y", 32'(Y), 32'd2);
        tick();
        check("r2_second_strobe", 32'(key_strobe), 32'd1);
        check("r2_second_code", 32'(key_code), 32'h12);
        check("r2_second_pressed", 32'(key_pressed), 32'd1);
        check("r2_second_y", 32'(Y), 32'd2);
        tick();
        check("r2_done_strobe", 32'(key_strobe), 32'd0);
        set_row(2, 8'h00);
        ticks(150);

        // Row 9 fully pulled low: only DEL is reported
        set_row(9, 8'hFF);
        wait_strobe("r9_strobe", 300);
        check("r9_code", 32'(key_code), 32'h66);
        check("r9_pressed", 32'(key_pressed), 32'd1);
        s0 = strobes;
        ticks(120);
        check("r9_single", 32'(strobes - s0), 32'd0);
        set_row(9, 8'h00);
        wait_strobe("r9_rel_strobe", 300);
        check("r9_rel_code", 32'(key_code), 32'h66);
        check("r9_rel_pressed", 32'(key_pressed), 32'd0);

        // ce low for 50 cycles in the middle of a settle period
        wait_not_row(3, 100);
        wait_row(3, 100);
        ticks(2);
        y_hold = Y;
        s0 = strobes;
        ce = 1'b0;
        ticks(50);
        check("ce_y_frozen", 32'(Y), 32'(y_hold));
        check("ce_no_strobe", 32'(strobes - s0), 32'd0);
        ce = 1'b1;
        ticks(2);
        check("ce_resume_y3", 32'(Y), 32'd3);
        tick();
        check("ce_resume_y4", 32'(Y), 32'd4);

        // Reset between the two events of row 5 ('8' and space)
        set_row(5, 8'h81);
        wait_strobe("rst_ev1_strobe", 300);
        check("rst_ev1_code", 32'(key_code), 32'h3E);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_strobe", 32'(key_strobe), 32'd0);
        check("rst_mid_code", 32'(key_code), 32'd0);
        check("rst_mid_pressed", 32'(key_pressed), 32'd0);
        check("rst_mid_y", 32'(Y), 32'd0);
        ticks(3);
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_strobe("rerun_ev1_strobe", 300);
        check("rerun_ev1_code", 32'(key_code), 32'h3E);
        check("rerun_ev1_pressed", 32'(key_pressed), 32'd1);
        tick();
        check("rerun_ev2_strobe", 32'(key_strobe), 32'd1);
        check("rerun_ev2_code", 32'(key_code), 32'h29);
        check("rerun_ev2_pressed", 32'(key_pressed), 32'd1);
        set_row(5, 8'h00);
        ticks(150);

        // Random key activity with occasional ce drops
        for (int it = 0; it < 4000; it++) begin
            tick();
            if ($urandom_range(0, 29) == 0) begin
                r = int'($urandom_range(0, 9));
                if (r != int'(Y)) kb[r] = kb[r] ^ (8'd1 << $urandom_range(0, 7));
            end
            if (ce && $urandom_range(0, 99) == 0) ce = 1'b0;
            else if (!ce && $urandom_range(0, 3) == 0) ce = 1'b1;
        end
        ce = 1'b1;
        for (int i = 0; i < 10; i++) set_row(i, 8'h00);
        ticks(200);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
